alu_issue_ctrl: RTL and testbench

//  Initiator side of the ALU operand/result interface. Accepts one operation

---
 rtl/alu_issue_ctrl_if.sv | 43 ++++
 rtl/alu_issue_ctrl.sv | 129 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - request, ALU and response bundle for alu_issue_ctrl
// Purpose: groups the request (req_*), ALU operand/result (alu_*) and response
//          (rsp_*, flags_q) signals of the ALU issue controller.
// Modports:
//   master - the controller: drives req_ready, alu_a/alu_b/alu_ctrl, rsp_*, flags_q
//   slave  - the environment: drives req_valid/op/a/b/tag, alu_result/alu_flags, rsp_ready
interface alu_issue_ctrl_if #(
  parameter int N     = 19,
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [N-1:0]     req_a;
  logic [N-1:0]     req_b;
  logic [TAG_W-1:0] req_tag;
  logic [N-1:0]     alu_a;
  logic [N-1:0]     alu_b;
  logic [2:0]       alu_ctrl;
  logic [N-1:0]     alu_result;
  logic [2:0]       alu_flags;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [N-1:0]     rsp_result;
  logic [2:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic [2:0]       flags_q;

  modport master (
    input  req_valid, req_op, req_a, req_b, req_tag,
    input  alu_result, alu_flags, rsp_ready,
    output req_ready, alu_a, alu_b, alu_ctrl,
    output rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err, flags_q
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, req_tag,
    output alu_result, alu_flags, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_ctrl,
    input  rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err, flags_q
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - multicycle ALU operand issue and result capture controller
// Purpose: accepts one op per request handshake, holds registered operands on the
//          ALU for a per-op window (DIV/MOD longer), captures Result/{Z,O,N} and
//          returns them on a backpressured response port; keeps committed flags.
// Ports:
//   clk      - rising-edge clock
//   reset_n  - asynchronous active-low reset
//   bus      - alu_issue_ctrl_if.master (req_*, alu_*, rsp_*, flags_q)
// Build option: ALU_ISSUE_DIVZERO_CHK_EN - reject DIV/MOD by zero with rsp_err
//               without issuing to the ALU.
module alu_issue_ctrl #(
  parameter int N        = 19,
  parameter int OP_WAIT  = 1,
  parameter int DIV_WAIT = 4,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_issue_ctrl_if.master bus
);

  generate
    if (OP_WAIT < 1 || DIV_WAIT < 1) begin : g_bad_wait
      $error("alu_issue_ctrl: OP_WAIT and DIV_WAIT must both be >= 1");
    end
  endgenerate

  localparam int MAX_WAIT = (DIV_WAIT > OP_WAIT) ? DIV_WAIT : OP_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] OP_CNT  = CNT_W'(OP_WAIT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_WAIT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     alu_a_q, alu_b_q, rsp_result_q;
  logic [2:0]       alu_ctrl_q, rsp_flags_q, flags_q_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             rsp_err_q;
  logic             req_ready_c, rsp_valid_c, capture;
  logic             accept, req_div, req_err;

  assign req_div = (bus.req_op == 3'b011) || (bus.req_op == 3'b100);

`ifdef ALU_ISSUE_DIVZERO_CHK_EN
  assign req_err = (bus.req_op == 3'b111) || (req_div && (bus.req_b == '0));
`else
  assign req_err = (bus.req_op == 3'b111);
`endif

  assign accept = bus.req_valid && req_ready_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        req_ready_c = 1'b1;
        // Rejected ops never touch the ALU window and answer immediately.
        if (bus.req_valid) state_nxt = req_err ? RESP : EXEC;
      end
      EXEC: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      rsp_tag_q    <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
      flags_q_q    <= '0;
      cnt          <= '0;
    end else begin
      if (accept) begin
        alu_a_q      <= bus.req_a;
        alu_b_q      <= bus.req_b;
        alu_ctrl_q   <= bus.req_op;
        rsp_tag_q    <= bus.req_tag;
        cnt          <= req_div ? DIV_CNT : OP_CNT;
        rsp_err_q    <= req_err;
        // Error responses report zero result/flags; normal ones overwrite at capture.
        rsp_result_q <= '0;
        rsp_flags_q  <= '0;
      end else if (state == EXEC) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        // The ALU output is only trusted once the full hold window has elapsed.
        if (capture) begin
          rsp_result_q <= bus.alu_result;
          rsp_flags_q  <= bus.alu_flags;
        end
      end
      if (rsp_valid_c && bus.rsp_ready && !rsp_err_q) flags_q_q <= rsp_flags_q;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.rsp_valid  = rsp_valid_c;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_ctrl   = alu_ctrl_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.flags_q    = flags_q_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - randomized self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;
  localparam int N     = 19;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.N(N), .TAG_W(TAG_W)) bus ();

  alu_issue_ctrl #(.N(N), .OP_WAIT(1), .DIV_WAIT(4), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] mdl_flags_q = 3'b000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Stand-in ALU: {Z,O,N, result}
  function automatic logic [N+2:0] alu_fn(input logic [2:0] op, input logic [N-1:0] a,
                                          input logic [N-1:0] b);
    logic [N-1:0]   r;
    logic           o;
    logic [2*N-1:0] p;
    r = '0;
    o = 1'b0;
    p = '0;
    case (op)
      3'd0: begin r = a + b; o = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]); end
      3'd1: begin r = a - b; o = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]); end
      3'd2: begin p = {{N{1'b0}}, a} * {{N{1'b0}}, b}; r = p[N-1:0]; end
      3'd3: r = (b == '0) ? '1 : a / b;
      3'd4: r = (b == '0) ? a : a % b;
      3'd5: r = a ^ b;
      3'd6: r = b;
      default: r = '0;
    endcase
    return {(r == '0), o, r[N-1], r};
  endfunction

  logic [N+2:0] alu_v;
  assign alu_v          = alu_fn(bus.alu_ctrl, bus.alu_a, bus.alu_b);
  assign bus.alu_result = alu_v[N-1:0];
  assign bus.alu_flags  = alu_v[N+2:N];

  task automatic do_op(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [TAG_W-1:0] tag, input int bp);
    logic [N+2:0] v;
    logic         exp_err;
    int           exp_lat;
    int           lat;
    int           k;
    exp_err = (op == 3'b111);
`ifdef ALU_ISSUE_DIVZERO_CHK_EN
    if ((op == 3'd3 || op == 3'd4) && b == '0) exp_err = 1'b1;
`endif
    exp_lat = exp_err ? 0 : ((op == 3'd3 || op == 3'd4) ? 4 : 1);
    v = exp_err ? '0 : alu_fn(op, a, b);

    @(negedge clk);
    k = 0;
    while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a     = N'($urandom);
    bus.req_b     = N'($urandom);
    bus.req_op    = 3'($urandom);
    bus.req_tag   = TAG_W'($urandom);

    lat = 0;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 20) begin
      check("exec_alu_a", 32'(bus.alu_a), 32'(a));
      check("exec_alu_b", 32'(bus.alu_b), 32'(b));
      check("exec_alu_ctrl", 32'(bus.alu_ctrl), 32'(op));
      check("exec_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));

    // Backpressure: offer a competing request that must not be taken.
    for (int i = 0; i < bp; i++) begin
      bus.req_valid = 1'b1;
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check("bp_result", 32'(bus.rsp_result), 32'(v[N-1:0]));
      check("bp_alu_a", 32'(bus.alu_a), 32'(a));
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    check("rsp_result", 32'(bus.rsp_result), 32'(v[N-1:0]));
    check("rsp_flags", 32'(bus.rsp_flags), 32'(v[N+2:N]));
    check("rsp_tag", 32'(bus.rsp_tag), 32'(tag));
    check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    check("flags_q_before", 32'(bus.flags_q), 32'(mdl_flags_q));
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    if (!exp_err) mdl_flags_q = v[N+2:N];
    @(negedge clk);
    check("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("post_req_ready", 32'(bus.req_ready), 32'd1);
    check("flags_q", 32'(bus.flags_q), 32'(mdl_flags_q));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]       r_op;
    logic [N-1:0]     r_a, r_b;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_flags_q", 32'(bus.flags_q), 32'd0);
    check("rst_alu_a", 32'(bus.alu_a), 32'd0);
    check("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    reset_n = 1'b1;

    do_op(3'd0, 19'd5, 19'd7, 4'd3, 0);
    do_op(3'd1, 19'd4, 19'd4, 4'd1, 0);
    do_op(3'd3, 19'd100, 19'd7, 4'd2, 0);
    do_op(3'd4, 19'd20, 19'd6, 4'd5, 10);
    do_op(3'd7, 19'd1, 19'd1, 4'd6, 0);
    do_op(3'd3, 19'd9, 19'd0, 4'd7, 0);
    do_op(3'd1, 19'd4, 19'd4, 4'd8, 0);

    // Reset in the middle of a DIV window: no response may follow.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd3;
    bus.req_a     = 19'd50;
    bus.req_b     = 19'd5;
    bus.req_tag   = 4'd9;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    mdl_flags_q = 3'b000;
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_flags_q", 32'(bus.flags_q), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    bus.rsp_ready = 1'b0;

    for (int i = 0; i < 60; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = N'($urandom);
      r_b  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      do_op(r_op, r_a, r_b, TAG_W'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
